// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu - clocked ALU with a registered result and a one-cycle Done pulse.
//
// A Start strobe, accepted only while Busy is low, captures A, B and Sel.
// Single-cycle operations register their result and flags on the same edge.
// MUL runs as a WIDTH-cycle shift-add loop and holds Busy high while it runs.
//
// Ports
//   Clk    in   system clock, rising edge
//   Rst_n  in   asynchronous active-low reset
//   Start  in   operation request (dropped while Busy)
//   Sel    in   [3:0] operation select
//   A, B   in   [WIDTH-1:0] operands
//   Q      out  [WIDTH-1:0] registered result
//   Flags  out  [3:0] registered {Z, N, C, V}
//   Busy   out  multiply in progress
//   Done   out  one-cycle completion pulse
//   Err    out  illegal Sel seen, held until the next accepted Start
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [3:0]       Sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [3:0]       Flags,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       q_q;
    logic [3:0]             flags_q;
    logic                   done_q;
    logic                   err_q;
    logic [2*WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]       mplier_q;
    logic [SHW-1:0]         cnt_q;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH:0]   add_w, sub_w, inc_w;
    logic [WIDTH:0]   shl_w, shr_w, sra_w;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] res;
    logic             c_f, v_f, upd_q, illegal;

    assign sh    = B[SHW-1:0];
    assign add_w = {1'b0, A} + {1'b0, B};
    assign sub_w = {1'b0, A} - {1'b0, B};   // top bit is the borrow
    assign inc_w = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};

    // One guard bit beside the operand catches the last bit shifted out;
    // with a zero amount the guard stays 0, so C=0 falls out naturally.
    assign shl_w = {1'b0, A} << sh;
    assign shr_w = {A, 1'b0} >> sh;
    assign sra_w = $signed({A, 1'b0}) >>> sh;

    always_comb begin
        res     = '0;
        c_f     = 1'b0;
        v_f     = 1'b0;
        upd_q   = 1'b1;
        illegal = 1'b0;
        case (Sel)
            4'd0: res = '0;
            4'd1: begin
                res = add_w[MSB:0];
                c_f = add_w[WIDTH];
                v_f = (A[MSB] == B[MSB]) && (res[MSB] != A[MSB]);
            end
            4'd2, 4'd12: begin
                res   = sub_w[MSB:0];
                c_f   = sub_w[WIDTH];
                v_f   = (A[MSB] != B[MSB]) && (res[MSB] != A[MSB]);
                upd_q = (Sel != 4'd12);   // CMP only touches Flags
            end
            4'd3: res = A;
            4'd4: res = A ^ B;
            4'd5: res = A | B;
            4'd6: res = A & B;
            4'd7: begin
                res = inc_w[MSB:0];
                c_f = inc_w[WIDTH];
                v_f = !A[MSB] && res[MSB];
            end
            4'd8: begin
                res = shl_w[MSB:0];
                c_f = shl_w[WIDTH];
            end
            4'd9: begin
                res = shr_w[WIDTH:1];
                c_f = shr_w[0];
            end
            4'd10: begin
                res = sra_w[WIDTH:1];
                c_f = sra_w[0];
            end
            4'd11: res = '0;              // handled by the MUL state
            default: illegal = 1'b1;      // res=0 gives Flags={1,0,0,0}
        endcase
    end

    // ---------------- multiply step ----------------
    logic [2*WIDTH-1:0] acc_nx;
    assign acc_nx = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // ---------------- control ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            q_q      <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        err_q <= 1'b0;
                        if (Sel == 4'd11) begin
                            mcand_q  <= {{WIDTH{1'b0}}, A};
                            mplier_q <= B;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            state_q  <= S_MUL;
                        end else begin
                            if (upd_q) q_q <= res;
                            flags_q <= {res == '0, res[MSB], c_f, v_f};
                            err_q   <= illegal;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_nx;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == SHW'(WIDTH - 1)) begin
                        q_q     <= acc_nx[MSB:0];
                        flags_q <= {acc_nx[MSB:0] == '0, acc_nx[MSB],
                                    |acc_nx[2*WIDTH-1:WIDTH], 1'b0};
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Q     = q_q;
    assign Flags = flags_q;
    assign Busy  = (state_q == S_MUL);
    assign Done  = done_q;
    assign Err   = err_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic [3:0]  Sel;
    logic [15:0] A, B;
    logic [15:0] Q;
    logic [3:0]  Flags;
    logic        Busy, Done, Err;

    int n_chk  = 0;
    int n_fail = 0;

    seq_alu #(.WIDTH(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Sel(Sel), .A(A), .B(B),
        .Q(Q), .Flags(Flags), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one Start pulse from a negedge; returns at the negedge after the
    // capturing edge, where a single-cycle result is already visible.
    task automatic do_op(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
        Start = 1'b1; Sel = s; A = a; B = b;
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0;
    endtask

    int busy_n;
    int got;
    int done_seen;

    initial begin
        Rst_n = 1'b0; Start = 1'b1; Sel = 4'd1; A = 16'h1111; B = 16'h2222;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_q", Q, 16'h0);
        chk("rst_flags", Flags, 4'h0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_err", Err, 1'b0);
        Start = 1'b0;
        Rst_n = 1'b1;
        @(posedge Clk); @(negedge Clk);
        chk("idle_done", Done, 1'b0);
        chk("idle_q", Q, 16'h0);

        // ADD carry-out wraps to zero
        do_op(4'd1, 16'hFFFF, 16'h0001);
        chk("add_done", Done, 1'b1);
        chk("add_q", Q, 16'h0000);
        chk("add_flags", Flags, 4'b1010);
        @(posedge Clk); @(negedge Clk);
        chk("add_done_drop", Done, 1'b0);

        // SUB signed overflow
        do_op(4'd2, 16'h8000, 16'h0001);
        chk("sub_q", Q, 16'h7FFF);
        chk("sub_flags", Flags, 4'b0001);

        // CMP leaves Q alone
        do_op(4'd12, 16'h0003, 16'h0005);
        chk("cmp_done", Done, 1'b1);
        chk("cmp_q", Q, 16'h7FFF);
        chk("cmp_flags", Flags, 4'b0110);

        // INC overflow
        do_op(4'd7, 16'h7FFF, 16'h1234);
        chk("inc_q", Q, 16'h8000);
        chk("inc_flags", Flags, 4'b0101);

        // MUL with an ADD pulse injected while busy
        do_op(4'd11, 16'h0123, 16'h0010);
        busy_n = 0; got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            if (Done) got = 1;
            else begin
                if (Busy) busy_n++;
                Start = (i == 3);
                if (i == 3) begin Sel = 4'd1; A = 16'h0001; B = 16'h0001; end
                @(posedge Clk); @(negedge Clk);
            end
        end
        Start = 1'b0;
        chk("mul1_done_seen", got, 1);
        chk("mul1_busy_cycles", busy_n, 16);
        chk("mul1_busy_at_done", Busy, 1'b0);
        chk("mul1_q", Q, 16'h1230);
        chk("mul1_flags", Flags, 4'b0000);

        // MUL overflow into the upper half
        do_op(4'd11, 16'h0100, 16'h0100);
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            if (Done) got = 1;
            else begin @(posedge Clk); @(negedge Clk); end
        end
        chk("mul2_done_seen", got, 1);
        chk("mul2_q", Q, 16'h0000);
        chk("mul2_flags", Flags, 4'b1010);

        // Shifts
        do_op(4'd8, 16'h8001, 16'h0001);
        chk("shl_q", Q, 16'h0002);
        chk("shl_flags", Flags, 4'b0010);
        do_op(4'd10, 16'h8004, 16'h0002);
        chk("sra_q", Q, 16'hE001);
        chk("sra_flags", Flags, 4'b0100);
        do_op(4'd9, 16'h8004, 16'h0002);
        chk("shr_q", Q, 16'h2001);
        chk("shr_flags", Flags, 4'b0000);
        do_op(4'd8, 16'h8001, 16'hFFF0);   // amount field 0
        chk("shl0_q", Q, 16'h8001);
        chk("shl0_flags", Flags, 4'b0100);

        // Illegal select
        do_op(4'd13, 16'h1234, 16'h5678);
        chk("ill_done", Done, 1'b1);
        chk("ill_err", Err, 1'b1);
        chk("ill_q", Q, 16'h0000);
        chk("ill_flags", Flags, 4'b1000);
        do_op(4'd1, 16'h0001, 16'h0002);
        chk("err_clear", Err, 1'b0);
        chk("add2_q", Q, 16'h0003);

        // Back-to-back with Start held
        Start = 1'b1; Sel = 4'd4; A = 16'h00F0; B = 16'h0FF0;
        @(posedge Clk); @(negedge Clk);
        chk("b2b_xor_q", Q, 16'h0F00);
        chk("b2b_xor_done", Done, 1'b1);
        Sel = 4'd6;
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0;
        chk("b2b_and_q", Q, 16'h00F0);
        chk("b2b_and_done", Done, 1'b1);

        // Reset mid-multiply
        do_op(4'd11, 16'h0123, 16'h0010);
        repeat (4) begin @(posedge Clk); @(negedge Clk); end
        chk("abort_busy_pre", Busy, 1'b1);
        Rst_n = 1'b0;
        #1;
        chk("abort_busy", Busy, 1'b0);
        chk("abort_done", Done, 1'b0);
        chk("abort_q", Q, 16'h0000);
        chk("abort_flags", Flags, 4'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(posedge Clk); @(negedge Clk);
            if (Done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        do_op(4'd1, 16'h0002, 16'h0002);
        chk("post_rst_q", Q, 16'h0004);
        chk("post_rst_done", Done, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, clocked ALU for the data path, succeeding the 8-operation combinational ALU. Operands and operation are captured on a Start strobe. Results and a Z/N/C/V flag set are registered, and completion is signalled by a one-cycle Done pulse. Single-cycle operations complete in 1 cycle. An iterative shift-add multiply takes WIDTH cycles and raises Busy while it runs. The control unit drives Start and waits on Done before sampling Q and Flags.

## Interface
- WIDTH, 16: data width; must be a power of two, ≥ 4.
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  operation request; accepted only when Busy = 0.
- Sel  in  4  operation select, captured with Start.
- A, B  in  WIDTH each  operands, captured with Start.
- Q  out  WIDTH  registered result.
- Flags  out  4  registered {Z, N, C, V}.
- Busy  out  1  multiply in progress.
- Done  out  1  one-cycle pulse; Q and Flags are valid from this cycle.
- Err  out  1  set with Done when Sel is illegal; cleared at the next accepted Start.

## Operation
- Sel encodings:
  - 0: zero.
  - 1: A+B.
  - 2: A−B.
  - 3: pass A.
  - 4: A^B.
  - 5: A|B.
  - 6: A&B.
  - 7: A+1.
  - 8: SHL A by B[log2(WIDTH)−1:0].
  - 9: SHR (logical), same amount field.
  - 10: SRA, same amount field.
  - 11: MUL, low WIDTH bits of the unsigned A×B.
  - 12: CMP, computes A−B; Q is left unchanged and only Flags update.
  - 13–15: illegal; Q=0, Flags={1,0,0,0}, Err=1.
- Flag rules:
  - Z = (result == 0).
  - N = result MSB.
  - ADD/INC: C = carry-out; V = signed overflow.
  - SUB/CMP: C = borrow (A < B unsigned); V = signed overflow.
  - Shifts: C = last bit shifted out, 0 when the amount is 0; V = 0.
  - MUL: C = 1 if the upper WIDTH bits of the full product are nonzero; V = 0.
  - Logic ops, pass and zero: C = V = 0.
- FSM states are IDLE and MUL.
  - In IDLE, an accepted Start with Sel ≠ 11 computes and registers the result in the same edge. The state stays IDLE.
  - In IDLE, Start with Sel = 11 loads the multiplicand, multiplier and a 2·WIDTH accumulator, clears the iteration counter, and moves to MUL.
  - In MUL, each edge processes one multiplier bit.
  - After WIDTH iterations the FSM registers Q and Flags, pulses Done, and returns to IDLE.
- A, B and Sel are ignored except on an accepted Start. Changes while Busy have no effect.
- Start while Busy = 1 is dropped silently: no queueing, no Err.
- Q and Flags hold until the next completing operation.

## Timing
- Reset values: Q=0, Flags=0, Busy=0, Done=0, Err=0, state IDLE, counter 0.
- Single-cycle operation: Start sampled at edge k → Q, Flags, Err and Done=1 visible after edge k; Done drops after edge k+1 unless a new op completes.
- MUL: Start at edge k → Busy=1 after edges k … k+WIDTH−1, i.e. exactly WIDTH cycles. Done=1 and Q/Flags update after edge k+WIDTH, with Busy=0 in that same cycle.
- Start asserted in the Done cycle (Busy=0) is accepted, giving back-to-back throughput. Single-cycle ops sustain one per cycle.
- Start held high continuously starts a new op each cycle that Busy=0.
- Rst_n low mid-multiply aborts immediately: no Done, outputs take their reset values. The first Start after Rst_n rises is honoured normally.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Test plan
- Reset: hold Rst_n=0 with Start=1 → Q=0, Flags=0, Busy=0, Done=0, Err=0. Release Rst_n → idle until the next Start edge.
- ADD 0xFFFF+0x0001 → Q=0x0000, Z=1, C=1, V=0, Done 1 cycle after Start. SUB 0x8000−0x0001 → Q=0x7FFF, V=1, C=0, N=0.
- CMP 3 vs 5 after the SUB above → Q stays 0x7FFF; Flags Z=0, N=1, C=1, V=0.
- MUL 0x0123×0x0010 → Busy high for exactly 16 cycles, Done after 16, Q=0x1230, C=0. An ADD Start pulsed mid-multiply is ignored. MUL 0x0100×0x0100 → Q=0, Z=1, C=1.
- Shifts: SHL 0x8001 by 1 → 0x0002, C=1. SRA 0x8004 by 2 → 0xE001, C=0, N=1. SHR 0x8004 by 2 → 0x2001.
- Illegal Sel=13 → Q=0, Err=1, Z=1, Done pulse. Next valid ADD clears Err. Rst_n low at MUL iteration 5 → Busy=0, no Done, Q=0.
